mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. Sits directly downstream of the register file: its two operands are the register file's Read_data1/Read_data2 outputs. It performs MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds HI/LO for MFHI/MFLO readout. Issue logic uses Busy to stall.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_iter_core.sv | 62 ++++++
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encodings and iteration constants for the multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int unsigned ITER_COUNT = 32;
    localparam logic [4:0]  LAST_ITER  = 5'(ITER_COUNT - 1);

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
        return en ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring shift-subtract divide.
module mdu_iter_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_prod,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_last
);

    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;

    logic [32:0] w_sum;
    logic [32:0] w_trial;

    // Upper half plus a carry bit; the low half holds the multiplier being consumed LSB first.
    assign w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_trial = {r_rem, r_quot[31]} - {1'b0, r_mcand};

    // Both datapaths step every cycle; the top picks the one matching the latched op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_acc   <= {32'd0, i_a};
            r_mcand <= i_b;
            r_quot  <= i_a;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (i_step) begin
            r_acc <= {w_sum, r_acc[31:1]};
            if (!w_trial[32]) begin
                r_rem  <= w_trial[31:0];
                r_quot <= {r_quot[30:0], 1'b1};
            end else begin
                r_rem  <= {r_rem[30:0], r_quot[31]};
                r_quot <= {r_quot[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign o_prod = r_acc;
    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    assign o_last = (r_cnt == LAST_ITER);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO. Define MDU_FAST_MULT_EN for a
// single-cycle combinational multiply; divide always iterates.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_d;
    logic        r_done;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic [31:0] r_raw_a;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_is_arith;
    logic        w_is_div;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_fast;
    logic        w_launch;
    logic        w_last;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_prod_fix;

    assign w_accept   = Start && (r_state == ST_IDLE);
    assign w_is_arith = ~Op[2];
    assign w_is_div   = Op[1];
    assign w_signed   = ~Op[0];
    assign w_a_neg    = w_signed & Operand_A[31];
    assign w_b_neg    = w_signed & Operand_B[31];
    assign w_abs_a    = neg32(Operand_A, w_a_neg);
    assign w_abs_b    = neg32(Operand_B, w_b_neg);

`ifdef MDU_FAST_MULT_EN
    logic [63:0] w_fast_mag;
    logic [63:0] w_fast_prod;

    assign w_fast      = w_accept & w_is_arith & ~w_is_div;
    assign w_fast_mag  = {32'd0, w_abs_a} * {32'd0, w_abs_b};
    assign w_fast_prod = (w_a_neg ^ w_b_neg) ? (64'd0 - w_fast_mag) : w_fast_mag;
`else
    assign w_fast = 1'b0;
`endif

    assign w_launch = w_accept & w_is_arith & ~w_fast;

    mdu_iter_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_launch),
        .i_step (r_state == ST_RUN),
        .i_a    (w_abs_a),
        .i_b    (w_abs_b),
        .o_prod (w_prod),
        .o_quot (w_quot),
        .o_rem  (w_rem),
        .o_last (w_last)
    );

    assign w_prod_fix = r_neg_q ? (64'd0 - w_prod) : w_prod;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: if (w_launch) w_state_d = ST_RUN;
            ST_RUN:  if (w_last) w_state_d = ST_FIX;
            ST_FIX:  w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_raw_a    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state <= w_state_d;
            r_done  <= (r_state == ST_FIX) | w_fast;
            if (w_launch) begin
                r_is_div   <= w_is_div;
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_a_neg;
                r_div_zero <= w_is_div && (Operand_B == 32'd0);
                r_raw_a    <= Operand_A;
            end
            if (r_state == ST_FIX) begin
                if (r_is_div && r_div_zero) begin
                    r_lo <= 32'hFFFF_FFFF;
                    r_hi <= r_raw_a;
                end else if (r_is_div) begin
                    r_lo <= neg32(w_quot, r_neg_q);
                    r_hi <= neg32(w_rem, r_neg_r);
                end else begin
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
                end
            end else if (w_accept && Op == OP_MTHI) begin
                r_hi <= Operand_A;
            end else if (w_accept && Op == OP_MTLO) begin
                r_lo <= Operand_A;
            end
`ifdef MDU_FAST_MULT_EN
            if (w_fast) begin
                r_hi <= w_fast_prod[63:32];
                r_lo <= w_fast_prod[31:0];
            end
`endif
        end
    end

    assign Busy = (r_state != ST_IDLE);
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, checked on each Done.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    time t_issue;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Op        (Op),
        .Operand_A (Operand_A),
        .Operand_B (Operand_B),
        .Busy      (Busy),
        .Done      (Done),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && Done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got HI=%h LO=%h expected no Done", HI, LO);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({HI, LO} !== e) begin
                    errors++;
                    $display("FAIL result: got HI=%h LO=%h expected HI=%h LO=%h",
                             HI, LO, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start     = 1'b1;
        Op        = op;
        Operand_A = a;
        Operand_B = b;
        @(posedge clk);
        t_issue = $time;
        #1;
        Start = 1'b0;
        Op    = 3'd6;
    endtask

    // Waits for Done with a bound; checks latency in edges and optionally Busy cycles.
    task automatic wait_done(input string name, input bit chk_busy);
        int  busy_n;
        bit  seen;
        longint lat;
        busy_n = 0;
        seen   = 0;
        lat    = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                seen = 1;
                lat  = longint'(($time - t_issue - 5) / 10);
            end else if (Busy === 1'b1) begin
                busy_n++;
            end
        end
        check({name, "_done_latency"}, 64'(lat), 64'd33);
        if (chk_busy) check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        exp_q.push_back({eh, el});
        issue(op, a, b);
        wait_done(name, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        Start     = 1'b0;
        Op        = 3'd6;
        Operand_A = '0;
        Operand_B = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_hi", 64'(HI), 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", 64'(HI), 64'hDEAD_BEEF);
        check("mthi_lo", 64'(LO), 64'h8000_0000);
        check("mthi_busy", 64'(Busy), 64'd0);
        @(negedge clk);
        check("mthi_no_done", 64'(Done), 64'd0);

        // MTLO and a second Start while a divide runs must both be dropped.
        exp_q.push_back({32'd0, 32'd100});
        issue(OP_DIVU, 32'd1000, 32'd10);
        begin
            time t_div;
            t_div = t_issue;
            repeat (5) @(negedge clk);
            issue(OP_MTLO, 32'd1, 32'd0);
            check("busy_mtlo_lo", 64'(LO), 64'h8000_0000);
            issue(OP_MULTU, 32'd3, 32'd3);
            check("busy_start_busy", 64'(Busy), 64'd1);
            t_issue = t_div;
        end
        wait_done("div_busy", 1'b0);
        repeat (40) @(negedge clk);
        check("after_div_idle", 64'(Busy), 64'd0);

        // Reset mid-multiply: nothing queued, so any later Done is flagged by the monitor.
        issue(OP_MULTU, 32'd5, 32'd6);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        check("midrst_hi", 64'(HI), 64'd0);
        check("midrst_lo", 64'(LO), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("postrst_idle", 64'(Busy), 64'd0);
        run_op("multu_after_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
